// File: rtl/rr_arb_pkg.sv
// Shared constants and state type for the round-robin select arbiter.
package rr_arb_pkg;

  localparam int unsigned NREQ         = 4;
  localparam int unsigned IDX_W        = 2;
  localparam int unsigned MAX_HOLD_DEF = 8;
  localparam int unsigned HOLD_W_DEF   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority scan: first set request bit starting at ptr, wrapping mod 4.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx  = '0;
    pick = '0;
    any  = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// Four-requester round-robin arbiter with registered grant index, hold limit
// and break-before-make gap between consecutive grants.
module rr_select_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned HOLD_W   = HOLD_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              valid_nxt, timeout_nxt;
  logic [IDX_W-1:0]  pick;
  logic              any;
  logic              rel_norm, rel_lim;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state and registered-output values; timeout only when the limit alone releases.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    timeout_nxt = 1'b0;
    rel_norm    = done | ~req[gnt_idx];
    rel_lim     = (hold_cnt == HOLD_LAST);

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (any) begin
          idx_nxt   = pick;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (rel_norm || rel_lim) begin
          valid_nxt   = 1'b0;
          ptr_nxt     = gnt_idx + IDX_W'(1);
          state_nxt   = IDLE;
          timeout_nxt = rel_lim & ~rel_norm;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
    endcase
  end

endmodule
